// File: rtl/sdram_dq_phy.sv
// W-lane SDRAM DQ pad interface: registered drive, negedge capture with posedge
// retime, CL-aligned read-valid, idle-only CL update, sticky collision guard.
// Optional macro SDRAM_DQ_PHY_EDGE_SEL_EN adds cfg_capture_posedge.
module sdram_dq_phy #(
  parameter int W          = 16,
  parameter int CL_MAX     = 3,
  parameter int CL_DEFAULT = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [$clog2(CL_MAX+1)-1:0] cfg_cl,
  output logic                        cl_busy,
  input  logic [W-1:0]                wdata,
  input  logic                        wdata_oe,
  input  logic                        rd_issue,
  output logic [W-1:0]                rdata,
  output logic                        rdata_valid,
  output logic                        err_collision,
  input  logic                        err_clr,
`ifdef SDRAM_DQ_PHY_EDGE_SEL_EN
  input  logic                        cfg_capture_posedge,
`endif
  inout  wire  [W-1:0]                dq
);

  localparam int CLW = $clog2(CL_MAX+1);

  logic [W-1:0]    dout_q, dout_d;
  logic [W-1:0]    oe_q, oe_d;
  logic [W-1:0]    cap_q, cap_d;
  logic [W-1:0]    rdata_q, rdata_d;
  logic [CL_MAX:0] vld_q, vld_d;
  logic            rdata_valid_q, rdata_valid_d;
  logic [CLW-1:0]  cl_q, cl_d;
  logic            err_q, err_d;
  logic            cl_busy_q, cl_busy_d;
  logic            in_win, cfg_ok, pending, pending_nxt;

  always_comb begin
    cfg_ok  = (cfg_cl != '0) && (32'(cfg_cl) <= 32'(CL_MAX));
    pending = cfg_ok && (cfg_cl != cl_q);

    // SDRAM owns the bus at edges E0+CL-1 and E0+CL; at edge E0+j the read
    // sits in stage j-1, and for CL=1 the first edge is the issue edge itself.
    in_win = (cl_q == CLW'(1)) && rd_issue;
    for (int unsigned k = 0; k <= CL_MAX; k++) begin
      if ((k + 1 == 32'(cl_q)) || (k + 2 == 32'(cl_q))) in_win = in_win | vld_q[k];
    end

    // Stages past the active CL are cleared so a consumed read can never
    // re-emerge after CL is raised.
    vld_d = {vld_q[CL_MAX-1:0], rd_issue};
    for (int unsigned k = 0; k <= CL_MAX; k++) begin
      if (k > 32'(cl_q)) vld_d[k] = 1'b0;
    end
    rdata_valid_d = vld_q[cl_q];

    cl_d = cl_q;
    if (pending && (vld_q == '0) && !rd_issue) cl_d = cfg_cl;
    pending_nxt = cfg_ok && (cfg_cl != cl_d);
    cl_busy_d   = (vld_d != '0) || pending_nxt;

    oe_d   = {W{wdata_oe & ~in_win}};
    dout_d = wdata;

    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (wdata_oe && in_win) err_d = 1'b1;

    cap_d   = dq;
    rdata_d = cap_q;
`ifdef SDRAM_DQ_PHY_EDGE_SEL_EN
    if (cfg_capture_posedge) rdata_d = dq;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q        <= '0;
      oe_q          <= '0;
      rdata_q       <= '0;
      vld_q         <= '0;
      rdata_valid_q <= 1'b0;
      cl_q          <= CLW'(CL_DEFAULT);
      err_q         <= 1'b0;
      cl_busy_q     <= 1'b0;
    end else begin
      dout_q        <= dout_d;
      oe_q          <= oe_d;
      rdata_q       <= rdata_d;
      vld_q         <= vld_d;
      rdata_valid_q <= rdata_valid_d;
      cl_q          <= cl_d;
      err_q         <= err_d;
      cl_busy_q     <= cl_busy_d;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) cap_q <= '0;
    else        cap_q <= cap_d;
  end

  for (genvar i = 0; i < W; i++) begin : g_lane
    assign dq[i] = oe_q[i] ? dout_q[i] : 1'bz;
  end

  assign rdata         = rdata_q;
  assign rdata_valid   = rdata_valid_q;
  assign err_collision = err_q;
  assign cl_busy       = cl_busy_q;

endmodule
